ex_stage: RTL and testbench

Execute stage of the five-stage RV32I pipeline: it takes decoded operands from the ID/EX register, computes the ALU result, branch/jump target and branch decision, and registers these together with the control fields into the EX/MEM pipeline register. It sits between `id_ex` and the memory stage. Instruction memory is a separate block and is not part of this stage.

---
 rtl/rv_pkg.sv | 51 +++++
 rtl/ex_alu.sv | 106 ++++++++++
 rtl/ex_stage.sv | 94 +++++++++
 tb/tb_ex_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I constants for the execute stage: datapath width, opcodes,
// funct3 encodings for ALU and branch operations, and the internal ALU op set.
package rv_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PC_ADD,
        ALU_JALR,
        ALU_PASS_B
    } alu_op_e;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU and branch compare for the execute stage: decodes the
// opcode/funct fields into an ALU operation and evaluates the branch decision.
module ex_alu
    import rv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [6:0]   opcode_i,
    input  logic [2:0]   funct3_i,
    input  logic         funct7_b5_i,
    input  logic [W-1:0] rs1_i,
    input  logic [W-1:0] rs2_i,
    input  logic [W-1:0] imm_i,
    input  logic [W-1:0] pc_i,
    output logic [W-1:0] alu_out_o,
    output logic         b_result_o
);

    alu_op_e              w_alu_op;
    logic [W-1:0]         w_op_b;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [W-1:0]         w_rs1_imm;
    logic                 w_lt_s;
    logic                 w_lt_u;
    logic                 w_br_eq;
    logic                 w_br_lt_s;
    logic                 w_br_lt_u;

    assign w_op_b    = (opcode_i == OPC_OP) ? rs2_i : imm_i;
    assign w_shamt   = w_op_b[SHAMT_W-1:0];
    assign w_rs1_imm = rs1_i + imm_i;
    assign w_lt_s    = $signed(rs1_i) < $signed(w_op_b);
    assign w_lt_u    = rs1_i < w_op_b;
    assign w_br_eq   = rs1_i == rs2_i;
    assign w_br_lt_s = $signed(rs1_i) < $signed(rs2_i);
    assign w_br_lt_u = rs1_i < rs2_i;

    always_comb begin
        w_alu_op = ALU_NONE;
        case (opcode_i)
            OPC_OP, OPC_OP_IMM: begin
                case (funct3_i)
                    // OP-IMM has no SUBI; its arithmetic-shift select lives in imm[10]
                    F3_ADD:  w_alu_op = (opcode_i == OPC_OP && funct7_b5_i) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  w_alu_op = ALU_SLL;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    F3_SLTU: w_alu_op = ALU_SLTU;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_SR: begin
                        if (opcode_i == OPC_OP)
                            w_alu_op = funct7_b5_i ? ALU_SRA : ALU_SRL;
                        else
                            w_alu_op = imm_i[10] ? ALU_SRA : ALU_SRL;
                    end
                    F3_OR:   w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_AND;
                endcase
            end
            OPC_LOAD, OPC_STORE:            w_alu_op = ALU_ADD;
            OPC_BRANCH, OPC_JAL, OPC_AUIPC: w_alu_op = ALU_PC_ADD;
            OPC_JALR:                       w_alu_op = ALU_JALR;
            OPC_LUI:                        w_alu_op = ALU_PASS_B;
            default:                        w_alu_op = ALU_NONE;
        endcase
    end

    always_comb begin
        alu_out_o = '0;
        case (w_alu_op)
            ALU_ADD:    alu_out_o = rs1_i + w_op_b;
            ALU_SUB:    alu_out_o = rs1_i - w_op_b;
            ALU_SLL:    alu_out_o = rs1_i << w_shamt;
            ALU_SLT:    alu_out_o = {{(W-1){1'b0}}, w_lt_s};
            ALU_SLTU:   alu_out_o = {{(W-1){1'b0}}, w_lt_u};
            ALU_XOR:    alu_out_o = rs1_i ^ w_op_b;
            ALU_SRL:    alu_out_o = rs1_i >> w_shamt;
            ALU_SRA:    alu_out_o = W'($signed(rs1_i) >>> w_shamt);
            ALU_OR:     alu_out_o = rs1_i | w_op_b;
            ALU_AND:    alu_out_o = rs1_i & w_op_b;
            ALU_PC_ADD: alu_out_o = pc_i + imm_i;
            ALU_JALR:   alu_out_o = {w_rs1_imm[W-1:1], 1'b0};
            ALU_PASS_B: alu_out_o = imm_i;
            default:    alu_out_o = '0;
        endcase
    end

    always_comb begin
        b_result_o = 1'b0;
        case (opcode_i)
            OPC_BRANCH: begin
                case (funct3_i)
                    F3_BEQ:  b_result_o = w_br_eq;
                    F3_BNE:  b_result_o = !w_br_eq;
                    F3_BLT:  b_result_o = w_br_lt_s;
                    F3_BGE:  b_result_o = !w_br_lt_s;
                    F3_BLTU: b_result_o = w_br_lt_u;
                    F3_BGEU: b_result_o = !w_br_lt_u;
                    default: b_result_o = 1'b0;
                endcase
            end
            OPC_JAL, OPC_JALR: b_result_o = 1'b1;
            default:           b_result_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU/branch evaluation feeding the EX/MEM register.
// Optional bubble insertion through flush_i when EX_FLUSH_EN is defined.
module ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] imm_ext_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] PC_i,
`ifdef EX_FLUSH_EN
    input  logic            flush_i,
`endif
    output logic [XLEN-1:0] alu_out_o,
    output logic [XLEN-1:0] link_o,
    output logic            B_result_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rs2_data_o
);

    logic [XLEN-1:0] w_alu_out;
    logic            w_b_result;
    logic            w_clear;

    logic [XLEN-1:0] r_alu_out;
    logic [XLEN-1:0] r_link;
    logic            r_b_result;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rs2_data;

    ex_alu #(.W(XLEN)) u_alu (
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .funct7_b5_i (funct7_i[5]),
        .rs1_i       (rs1_data_i),
        .rs2_i       (rs2_data_i),
        .imm_i       (imm_ext_i),
        .pc_i        (PC_i),
        .alu_out_o   (w_alu_out),
        .b_result_o  (w_b_result)
    );

    // A flush loads the same all-zero bubble as reset; opcode 0 marks it downstream.
`ifdef EX_FLUSH_EN
    assign w_clear = !rst_n || flush_i;
`else
    assign w_clear = !rst_n;
`endif

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_alu_out  <= '0;
            r_link     <= '0;
            r_b_result <= 1'b0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7   <= '0;
            r_rd       <= '0;
            r_rs2_data <= '0;
        end else begin
            r_alu_out  <= w_alu_out;
            r_link     <= PC_i + XLEN'(4);
            r_b_result <= w_b_result;
            r_opcode   <= opcode_i;
            r_funct3   <= funct3_i;
            r_funct7   <= funct7_i;
            r_rd       <= rd_i;
            r_rs2_data <= rs2_data_i;
        end
    end

    assign alu_out_o  = r_alu_out;
    assign link_o     = r_link;
    assign B_result_o = r_b_result;
    assign opcode_o   = r_opcode;
    assign funct3_o   = r_funct3;
    assign funct7_o   = r_funct7;
    assign rd_o       = r_rd;
    assign rs2_data_o = r_rs2_data;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued as each
// instruction is driven and compared one edge later. Flush cases need EX_FLUSH_EN.
module tb_ex_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] link;
        logic        br;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] rs2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_i;
    logic [31:0] imm_ext_i, rs1_data_i, rs2_data_i, PC_i;
    logic [6:0]  opcode_i, funct7_i;
    logic [2:0]  funct3_i;
    logic        flush;
    logic [31:0] alu_out_o, link_o, rs2_data_o;
    logic        B_result_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [2:0]  funct3_o;
    logic [4:0]  rd_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_i       (rd_i),
        .imm_ext_i  (imm_ext_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .funct7_i   (funct7_i),
        .PC_i       (PC_i),
`ifdef EX_FLUSH_EN
        .flush_i    (flush),
`endif
        .alu_out_o  (alu_out_o),
        .link_o     (link_o),
        .B_result_o (B_result_o),
        .opcode_o   (opcode_o),
        .funct3_o   (funct3_o),
        .funct7_o   (funct7_o),
        .rd_o       (rd_o),
        .rs2_data_o (rs2_data_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Independent reference written from the ISA description.
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] pc);
        exp_t e;
        logic [31:0] y;
        logic [4:0]  sh;
        logic        arith;
        e = '0;
        e.link = pc + 32'd4;
        e.opc = opc; e.f3 = f3; e.f7 = f7; e.rd = rd; e.rs2 = b;
        y     = (opc == 7'b0110011) ? b : imm;
        sh    = y[4:0];
        arith = (opc == 7'b0110011) ? f7[5] : imm[10];
        case (opc)
            7'b0110011, 7'b0010011: begin
                case (f3)
                    3'd0: e.alu = (opc == 7'b0110011 && f7[5]) ? a - y : a + y;
                    3'd1: e.alu = a << sh;
                    3'd2: e.alu = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd3: e.alu = (a < y) ? 32'd1 : 32'd0;
                    3'd4: e.alu = a ^ y;
                    3'd5: e.alu = arith ? 32'($signed(a) >>> sh) : a >> sh;
                    3'd6: e.alu = a | y;
                    3'd7: e.alu = a & y;
                endcase
            end
            7'b0000011, 7'b0100011: e.alu = a + imm;
            7'b1100011: begin
                e.alu = pc + imm;
                case (f3)
                    3'd0: e.br = (a == b);
                    3'd1: e.br = (a != b);
                    3'd4: e.br = $signed(a) < $signed(b);
                    3'd5: e.br = $signed(a) >= $signed(b);
                    3'd6: e.br = a < b;
                    3'd7: e.br = a >= b;
                    default: e.br = 1'b0;
                endcase
            end
            7'b1101111: begin e.alu = pc + imm; e.br = 1'b1; end
            7'b1100111: begin e.alu = (a + imm) & 32'hFFFF_FFFE; e.br = 1'b1; end
            7'b0110111: e.alu = imm;
            7'b0010111: e.alu = pc + imm;
            default: e.alu = 32'd0;
        endcase
        return e;
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_alu"},  alu_out_o,  e.alu);
        check({tag, "_link"}, link_o,     e.link);
        check({tag, "_br"},   {31'd0, B_result_o}, {31'd0, e.br});
        check({tag, "_opc"},  {25'd0, opcode_o},   {25'd0, e.opc});
        check({tag, "_f3"},   {29'd0, funct3_o},   {29'd0, e.f3});
        check({tag, "_f7"},   {25'd0, funct7_o},   {25'd0, e.f7});
        check({tag, "_rd"},   {27'd0, rd_o},       {27'd0, e.rd});
        check({tag, "_rs2"},  rs2_data_o, e.rs2);
    endtask

    // Drive one instruction, queue its expectation (zeros if reset/flush), compare after the edge.
    task automatic issue(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [31:0] imm,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic rst_v, input logic fl_v);
        exp_t e;
        opcode_i = opc; funct3_i = f3; funct7_i = f7; rd_i = rd;
        imm_ext_i = imm; rs1_data_i = a; rs2_data_i = b; PC_i = pc;
        rst_n = rst_v; flush = fl_v;
        e = model(opc, f3, f7, rd, imm, a, b, pc);
`ifdef EX_FLUSH_EN
        if (!rst_v || fl_v) e = '0;
`else
        if (!rst_v) e = '0;
`endif
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        logic [6:0] opc_tab [10];
        opc_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        flush = 1'b0;
        rst_n = 1'b0;
        opcode_i = '0; funct3_i = '0; funct7_i = '0; rd_i = '0;
        imm_ext_i = '0; rs1_data_i = '0; rs2_data_i = '0; PC_i = '0;

        // Reset held two cycles with a valid ADD on the inputs.
        issue("rst0", 7'b0110011, 3'd0, 7'h00, 5'd3, 32'h0, 32'h20, 32'h20, 32'h100, 1'b0, 1'b0);
        issue("rst1", 7'b0110011, 3'd0, 7'h00, 5'd3, 32'h0, 32'h20, 32'h20, 32'h100, 1'b0, 1'b0);

        issue("add",   7'b0110011, 3'd0, 7'h00, 5'd1, 32'h0,   32'h20, 32'h20, 32'h0,  1'b1, 1'b0);
        check("add_const", alu_out_o, 32'h40);
        issue("sub",   7'b0110011, 3'd0, 7'h20, 5'd2, 32'h0,   32'h20, 32'h20, 32'h4,  1'b1, 1'b0);
        check("sub_const", alu_out_o, 32'h0);
        issue("beq",   7'b1100011, 3'd0, 7'h00, 5'd0, 32'h10,  32'h20, 32'h20, 32'h8,  1'b1, 1'b0);
        check("beq_const", {alu_out_o[31:1], B_result_o}, {31'h0C, 1'b1});
        issue("bne",   7'b1100011, 3'd1, 7'h00, 5'd0, 32'h10,  32'h20, 32'h20, 32'h8,  1'b1, 1'b0);
        check("bne_const", {31'd0, B_result_o}, 32'd0);
        issue("srai",  7'b0010011, 3'd5, 7'h20, 5'd5, 32'h404, 32'h8000_0000, 32'h0, 32'hC, 1'b1, 1'b0);
        check("srai_const", alu_out_o, 32'hF800_0000);
        issue("sltu",  7'b0110011, 3'd3, 7'h00, 5'd6, 32'h0,   32'hFFFF_FFFF, 32'h1, 32'h10, 1'b1, 1'b0);
        check("sltu_const", alu_out_o, 32'h0);
        issue("jalr",  7'b1100111, 3'd0, 7'h00, 5'd1, 32'h0,   32'h101, 32'h0, 32'h40, 1'b1, 1'b0);
        check("jalr_const", alu_out_o, 32'h100);
        check("jalr_link",  link_o, 32'h44);
        issue("addi_f7", 7'b0010011, 3'd0, 7'h20, 5'd7, 32'h5, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
        check("addi_const", alu_out_o, 32'h15);
        issue("br_010", 7'b1100011, 3'd2, 7'h00, 5'd0, 32'h4, 32'h1, 32'h1, 32'h20, 1'b1, 1'b0);
        issue("illegal", 7'b1111111, 3'd7, 7'h7F, 5'd31, 32'hABCD, 32'h1, 32'h2, 32'h30, 1'b1, 1'b0);
        check("illegal_const", alu_out_o, 32'h0);

        // Mid-stream reset discards in-flight instruction; next one lands after one edge.
        issue("rst_mid", 7'b1101111, 3'd0, 7'h00, 5'd1, 32'h80, 32'h0, 32'h0, 32'h50, 1'b0, 1'b0);
        issue("post_rst", 7'b0110111, 3'd0, 7'h00, 5'd9, 32'h1234_5000, 32'h0, 32'h0, 32'h54, 1'b1, 1'b0);
        check("post_rst_const", alu_out_o, 32'h1234_5000);

`ifdef EX_FLUSH_EN
        issue("flush", 7'b0110011, 3'd0, 7'h00, 5'd1, 32'h0, 32'h20, 32'h20, 32'h60, 1'b1, 1'b1);
        check("flush_const", alu_out_o, 32'h0);
        issue("rst_over_flush", 7'b0110011, 3'd0, 7'h00, 5'd1, 32'h0, 32'h20, 32'h20, 32'h60, 1'b0, 1'b1);
        issue("after_flush", 7'b0110011, 3'd0, 7'h00, 5'd1, 32'h0, 32'h20, 32'h20, 32'h60, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [6:0] opc;
            logic [2:0] f3;
            logic [6:0] f7;
            logic [31:0] imm;
            opc = opc_tab[$urandom_range(0, 9)];
            f3  = 3'($urandom_range(0, 7));
            f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            imm = $urandom();
            if (i % 4 == 0) imm = {20'd0, 2'b00, imm[10], 9'd0} | {27'd0, imm[4:0]};
            issue("rnd", opc, f3, f7, 5'($urandom_range(0, 31)), imm,
                  $urandom(), (i % 5 == 0) ? 32'h7 : $urandom(), $urandom(), 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
